mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the multi-cycle processor's single unified memory port between the instruction-fetch requester and the load/store requester. It handles arbitration, wait-state sequencing and response return. It sits between the control/datapath and the memory, and drives the memory address, write data and read/write strobes that the top level exposes for debug. Each transaction holds the port for a fixed, parameterised number of wait cycles. Ties are broken round-robin.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory access cycles per transaction (legal 1..7)

- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on CLK rising edge
- if_req  in  1  fetch request (level, held until if_ack)
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched word
- ls_req  in  1  load/store request (level, held until ls_ack)
- ls_we  in  1  1=store, 0=load; stable while ls_req
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_ack  out  1  one-cycle pulse: load/store complete
- ls_rdata  out  DATA_W  load data
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W  memory read data
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- arb_state  out  2  current FSM state (debug)
- owner  out  1  granted requester, 0=fetch, 1=load/store

## Operation
- States: IDLE(0), ACCESS(1), RESP(2). Encoding 3 is unreachable and recovers to IDLE.
- IDLE transitions:
  - no request: stay in IDLE.
  - one request: grant it.
  - both requests: grant the requester not named by last_grant.
  - On grant: latch owner, address, write data and we; load wait counter with MEM_LAT-1; go to ACCESS; last_grant ← owner.
- ACCESS:
  - mem_read=1 for every ACCESS cycle of a load or fetch.
  - mem_write=1 only in the first ACCESS cycle of a store.
  - Counter decrements each cycle. At count 0, capture mem_data_out into the owner's rdata register (loads and fetches only) and go to RESP.
- RESP: owner's ack=1 for exactly this cycle, then IDLE unconditionally.
- Requester protocol:
  - Requester must keep req high and inputs stable from assertion through its ack cycle.
  - Req still high in the cycle after ack is a new request.
- Fetch is read-only. if_rdata and ls_rdata hold their value until their next capture. A store leaves ls_rdata unchanged.
- mem_address and mem_data_in change only on grant and hold otherwise.
- Only one transaction is in flight at a time. No request is dropped. Round-robin guarantees each requester waits at most one foreign transaction.
- Reset (reset=0 at an edge):
  - state→IDLE; last_grant→1, so fetch wins the first tie; owner→0.
  - All strobes, acks, rdata, mem_address, mem_data_in→0.
  - Reset mid-ACCESS aborts without ack. A store whose first ACCESS cycle has already passed has been committed to memory.

## Timing
- Grant decision is made in an IDLE cycle t where req=1. Strobes are asserted in cycles t+1..t+MEM_LAT. Ack is in cycle t+MEM_LAT+1.
- Request-to-ack latency is MEM_LAT+1 cycles. Minimum spacing between grants is MEM_LAT+2 cycles.
- mem_data_out is sampled at the rising edge ending the last ACCESS cycle. It must be valid then, i.e. memory read latency ≤ MEM_LAT cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- Counter is 3 bits wide. With MEM_LAT=1, ACCESS lasts one cycle.

## Structure
- Package mem_arb_pkg holds:
  - state typedef/constants: IDLE, ACCESS, RESP;
  - owner constants: OWN_IF=0, OWN_LS=1;
  - MEM_LAT legal-range check constant.
- The 2-way round-robin picker is a small natural sub-module, rr_pick2: inputs req[1:0] and last; output grant_valid and grant_id. It is combinational. last_grant stays in the parent.
- Everything else (FSM, counter, latches) lives in mem_port_arbiter.

## Test plan
- Single fetch, MEM_LAT=2: if_req at t, if_addr=0x10, memory returns 0xE3A01005 → mem_read high t+1..t+2, mem_address=0x10, if_ack pulse at t+3, if_rdata=0xE3A01005, mem_write never high.
- Store: ls_req, ls_we=1, ls_addr=0x40, ls_wdata=0xDEADBEEF → mem_write high only in t+1, mem_data_in=0xDEADBEEF, ls_ack at t+3, ls_rdata unchanged.
- Tie after reset: if_req and ls_req raised together and held → grant order fetch, ls, fetch, ls; owner alternates; acks alternate every 4 cycles.
- Back-to-back fetch alone, req held high → ack every MEM_LAT+2=4 cycles, no lost or duplicate ack.
- Reset mid-ACCESS: reset=0 during second ACCESS cycle of a load → next cycle arb_state=0, all strobes/acks 0, ls_rdata=0, no ls_ack. After reset release, a re-asserted request completes normally.
- MEM_LAT=1 and MEM_LAT=7 sweeps → ack exactly MEM_LAT+1 cycles after request, strobe widths 1 and 7 respectively.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;

    function automatic bit mem_lat_ok(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        case (req)
            2'b11:   grant_id = ~last;
            2'b10:   grant_id = 1'b1;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store requesters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        arb_state,
    output logic              owner
);

    if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT out of range 1..7");
    end

    arb_state_t state, next_state;
    logic [2:0] cnt;
    logic       last_grant;
    logic       we_r;
    logic       grant_valid;
    logic       grant_id;
    logic       start;
    logic       finish;

    rr_pick2 u_pick (
        .req         ({ls_req, if_req}),
        .last        (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        next_state = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    next_state = ACCESS;
                    start      = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == 3'd0) begin
                    next_state = RESP;
                    finish     = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign arb_state = state;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            last_grant  <= OWN_LS;
            we_r        <= 1'b0;
            owner       <= OWN_IF;
            if_ack      <= 1'b0;
            ls_ack      <= 1'b0;
            if_rdata    <= '0;
            ls_rdata    <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            state     <= next_state;
            if_ack    <= finish && (owner == OWN_IF);
            ls_ack    <= finish && (owner == OWN_LS);
            // A store strobes write once; the remaining ACCESS cycles are pure wait states.
            mem_write <= start && (grant_id == OWN_LS) && ls_we;
            if (start) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                cnt        <= 3'(MEM_LAT - 1);
                mem_read   <= !((grant_id == OWN_LS) && ls_we);
                if (grant_id == OWN_LS) begin
                    mem_address <= ls_addr;
                    mem_data_in <= ls_wdata;
                    we_r        <= ls_we;
                end else begin
                    mem_address <= if_addr;
                    we_r        <= 1'b0;
                end
            end else begin
                if (next_state != ACCESS) begin
                    mem_read <= 1'b0;
                end
                if ((state == ACCESS) && (cnt != 3'd0)) begin
                    cnt <= cnt - 3'd1;
                end
            end
            if (finish && !we_r) begin
                if (owner == OWN_IF) begin
                    if_rdata <= mem_data_out;
                end else begin
                    ls_rdata <= mem_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_ack, ls_ack, mem_read, mem_write, owner;
    logic [31:0] if_rdata, ls_rdata, mem_address, mem_data_in, mem_data_out;
    logic [1:0]  arb_state;

    logic        l1_req, l1_ack, l1_lsack, l1_rd, l1_wr, l1_own;
    logic [31:0] l1_addr, l1_rdata, l1_lsrdata, l1_maddr, l1_mdin, l1_mdo;
    logic [1:0]  l1_st;
    logic        l7_req, l7_ack, l7_lsack, l7_rd, l7_wr, l7_own;
    logic [31:0] l7_addr, l7_rdata, l7_lsrdata, l7_maddr, l7_mdin, l7_mdo;
    logic [1:0]  l7_st;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h10) return 32'hE3A01005;
        return {~a[15:0], a[15:0]};
    endfunction

    assign mem_data_out = mem_f(mem_address);
    assign l1_mdo       = mem_f(l1_maddr);
    assign l7_mdo       = mem_f(l7_maddr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .CLK(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_read(mem_read), .mem_write(mem_write), .arb_state(arb_state), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_l1 (
        .CLK(clk), .reset(rst_n),
        .if_req(l1_req), .if_addr(l1_addr), .if_ack(l1_ack), .if_rdata(l1_rdata),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
        .ls_ack(l1_lsack), .ls_rdata(l1_lsrdata),
        .mem_address(l1_maddr), .mem_data_in(l1_mdin), .mem_data_out(l1_mdo),
        .mem_read(l1_rd), .mem_write(l1_wr), .arb_state(l1_st), .owner(l1_own)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(7)) u_l7 (
        .CLK(clk), .reset(rst_n),
        .if_req(l7_req), .if_addr(l7_addr), .if_ack(l7_ack), .if_rdata(l7_rdata),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
        .ls_ack(l7_lsack), .ls_rdata(l7_lsrdata),
        .mem_address(l7_maddr), .mem_data_in(l7_mdin), .mem_data_out(l7_mdo),
        .mem_read(l7_rd), .mem_write(l7_wr), .arb_state(l7_st), .owner(l7_own)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        lreq;
        logic        lwe;
        logic [31:0] laddr;
        logic [31:0] lwd;
        logic [1:0]  st;
        logic        rd, wr, ia, la, own;
        logic [31:0] ma, md, ird, lrd;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(input logic ireq, input logic lreq, input logic lwe,
                                input logic [31:0] laddr, input logic [1:0] st,
                                input logic rd, input logic wr, input logic ia,
                                input logic la, input logic own, input logic [31:0] ma,
                                input logic [31:0] md, input logic [31:0] ird,
                                input logic [31:0] lrd);
        vec_t v;
        v.ireq = ireq; v.iaddr = 32'h10; v.lreq = lreq; v.lwe = lwe;
        v.laddr = laddr; v.lwd = 32'hDEADBEEF;
        v.st = st; v.rd = rd; v.wr = wr; v.ia = ia; v.la = la; v.own = own;
        v.ma = ma; v.md = md; v.ird = ird; v.lrd = lrd;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] snap();
        return {arb_state, mem_read, mem_write, if_ack, ls_ack, owner,
                mem_address, mem_data_in, if_rdata, ls_rdata};
    endfunction

    initial begin
        int l1_c, l7_c, l1_w, l7_w;
        if_req = 0; ls_req = 0; ls_we = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0;
        l1_req = 0; l7_req = 0; l1_addr = 32'h8; l7_addr = 32'h18;
        rst_n = 0;

        vt[0]  = mk(1, 0, 0, 32'h0,  2'd0, 0, 0, 0, 0, 0, 32'h0,  32'h0,        32'h0,        32'h0);
        vt[1]  = mk(1, 0, 0, 32'h0,  2'd1, 1, 0, 0, 0, 0, 32'h10, 32'h0,        32'h0,        32'h0);
        vt[2]  = mk(1, 0, 0, 32'h0,  2'd1, 1, 0, 0, 0, 0, 32'h10, 32'h0,        32'h0,        32'h0);
        vt[3]  = mk(1, 0, 0, 32'h0,  2'd2, 0, 0, 1, 0, 0, 32'h10, 32'h0,        32'hE3A01005, 32'h0);
        vt[4]  = mk(0, 1, 1, 32'h40, 2'd0, 0, 0, 0, 0, 0, 32'h10, 32'h0,        32'hE3A01005, 32'h0);
        vt[5]  = mk(0, 1, 1, 32'h40, 2'd1, 0, 1, 0, 0, 1, 32'h40, 32'hDEADBEEF, 32'hE3A01005, 32'h0);
        vt[6]  = mk(0, 1, 1, 32'h40, 2'd1, 0, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 32'hE3A01005, 32'h0);
        vt[7]  = mk(0, 1, 1, 32'h40, 2'd2, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 32'hE3A01005, 32'h0);
        vt[8]  = mk(0, 1, 0, 32'h20, 2'd0, 0, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 32'hE3A01005, 32'h0);
        vt[9]  = mk(0, 1, 0, 32'h20, 2'd1, 1, 0, 0, 0, 1, 32'h20, 32'hDEADBEEF, 32'hE3A01005, 32'h0);
        vt[10] = mk(0, 1, 0, 32'h20, 2'd1, 1, 0, 0, 0, 1, 32'h20, 32'hDEADBEEF, 32'hE3A01005, 32'h0);
        vt[11] = mk(0, 1, 0, 32'h20, 2'd2, 0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 32'hE3A01005, 32'hFFDF0020);
        vt[12] = mk(0, 0, 0, 32'h20, 2'd0, 0, 0, 0, 0, 1, 32'h20, 32'hDEADBEEF, 32'hE3A01005, 32'hFFDF0020);

        repeat (3) next_cycle();
        @(negedge clk);
        check("reset_state", snap(), 160'h0);
        next_cycle();
        rst_n = 1;

        // Single fetch, store, load: one vector per cycle.
        for (int i = 0; i < 13; i++) begin
            if_req = vt[i].ireq; if_addr = vt[i].iaddr;
            ls_req = vt[i].lreq; ls_we = vt[i].lwe;
            ls_addr = vt[i].laddr; ls_wdata = vt[i].lwd;
            @(negedge clk);
            check($sformatf("vec%0d", i), snap(),
                  {vt[i].st, vt[i].rd, vt[i].wr, vt[i].ia, vt[i].la, vt[i].own,
                   vt[i].ma, vt[i].md, vt[i].ird, vt[i].lrd});
            next_cycle();
        end

        // Tie after reset: fetch wins first, then strict alternation.
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        if_req = 1; if_addr = 32'h10; ls_req = 1; ls_we = 0; ls_addr = 32'h40;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("tie_acks_c%0d", c), {if_ack, ls_ack},
                  {(c == 3 || c == 11), (c == 7 || c == 15)});
            if (c % 4 == 1) check($sformatf("tie_owner_c%0d", c), owner, (c % 8 == 5));
            next_cycle();
        end
        if_req = 0; ls_req = 0;
        @(negedge clk);
        check("tie_ls_rdata", ls_rdata, 32'hFFBF0040);
        next_cycle();

        // Back-to-back fetch with request held high.
        if_req = 1; if_addr = 32'h10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ack_c%0d", c), {if_ack, ls_ack}, {(c % 4 == 3), 1'b0});
            next_cycle();
        end
        if_req = 0;
        next_cycle();

        // Reset during the second ACCESS cycle of a load.
        ls_req = 1; ls_we = 0; ls_addr = 32'h20;
        next_cycle();
        next_cycle();
        rst_n = 0;
        @(negedge clk);
        check("rst_pre_edge", {arb_state, mem_read}, {2'd1, 1'b1});
        next_cycle();
        @(negedge clk);
        check("rst_abort", snap(), 160'h0);
        next_cycle();
        rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rst_retry_c%0d", c), {ls_ack, if_ack}, {(c == 3), 1'b0});
            if (c == 3) check("rst_retry_rdata", ls_rdata, 32'hFFDF0020);
            if (c == 3) ls_req = 0;
            next_cycle();
        end

        // MEM_LAT sweeps on the 1- and 7-cycle instances.
        l1_c = -1; l7_c = -1; l1_w = 0; l7_w = 0;
        l1_req = 1; l7_req = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (l1_c < 0 && l1_rd) l1_w++;
            if (l7_c < 0 && l7_rd) l7_w++;
            if (l1_c < 0 && l1_ack) l1_c = c;
            if (l7_c < 0 && l7_ack) l7_c = c;
            next_cycle();
            if (l1_c >= 0) l1_req = 0;
            if (l7_c >= 0) l7_req = 0;
        end
        check("lat1_ack_cycle", 160'(l1_c), 160'd2);
        check("lat1_strobe_width", 160'(l1_w), 160'd1);
        check("lat1_rdata", l1_rdata, 32'hFFF70008);
        check("lat7_ack_cycle", 160'(l7_c), 160'd8);
        check("lat7_strobe_width", 160'(l7_w), 160'd7);
        check("lat7_rdata", l7_rdata, 32'hFFE70018);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
